// File: rtl/tsc_pkg.sv
// Shared types and constants for the transient signal capture controller.
package tsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_ARMED    = 3'd2,
    S_POST     = 3'd3,
    S_WAIT_SBF = 3'd4,
    S_SEND     = 3'd5,
    S_DONE     = 3'd6
  } tsc_state_e;

  localparam logic [1:0] MODE_RISE   = 2'd0;
  localparam logic [1:0] MODE_FALL   = 2'd1;
  localparam logic [1:0] MODE_LEVEL  = 2'd2;
  localparam logic [1:0] MODE_MANUAL = 2'd3;

  // Pointer width for a buffer of the given depth (never narrower than 1 bit).
  function automatic int tsc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tsc_ring_ram.sv
// Circular sample store: synchronous write port, asynchronous read port.
module tsc_ring_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int PW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the accepted sample; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tsc_capture.sv
// Capture controller: continuous ADC sampling into a ring buffer, threshold
// trigger with pre/post history, then oldest-first streaming over valid/ready.
module tsc_capture
  import tsc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int PRE    = 16,
  parameter int PW     = tsc_ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              SBF,
  input  logic [DATA_W-1:0] threshold,
  input  logic [1:0]        trig_mode,
  input  logic              force_trig,
  output logic              adc_request,
  input  logic              adc_ready,
  input  logic [DATA_W-1:0] adc_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [2:0]        state,
  output logic [PW-1:0]     read_ptr_out,
  output logic [PW-1:0]     write_ptr_out,
  output logic [PW-1:0]     remaining_values_out,
  output logic              TRD,
  output logic              SD,
  output logic              CD
);

  localparam int POST_N = DEPTH - PRE - 1;

  tsc_state_e        state_q, state_d;
  logic [PW-1:0]     write_ptr, read_ptr, fill_cnt, remaining, send_cnt;
  logic [DATA_W-1:0] prev_sample, rd_data;
  logic              accept, fire, handshake;

  // Unsigned trigger test of the new sample against the previous one.
  function automatic logic trig_hit(input logic [1:0]        mode,
                                    input logic [DATA_W-1:0] p,
                                    input logic [DATA_W-1:0] s,
                                    input logic [DATA_W-1:0] t,
                                    input logic              frc);
    case (mode)
      MODE_RISE:  return (p < t) && (s >= t);
      MODE_FALL:  return (p >= t) && (s < t);
      MODE_LEVEL: return (s >= t);
      default:    return frc;
    endcase
  endfunction

  assign accept    = adc_ready && ((state_q == S_FILL) || (state_q == S_ARMED) ||
                                   (state_q == S_POST));
  assign fire      = accept && (state_q == S_ARMED) &&
                     trig_hit(trig_mode, prev_sample, adc_data, threshold, force_trig);
  assign handshake = (state_q == S_SEND) && tx_ready;

  tsc_ring_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (write_ptr),
    .wdata (adc_data),
    .raddr (read_ptr),
    .rdata (rd_data)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start) state_d = (PRE == 0) ? S_ARMED : S_FILL;
      S_FILL:     if (accept && (fill_cnt + 1'b1 == PW'(PRE))) state_d = S_ARMED;
      S_ARMED:    if (fire) state_d = (POST_N == 0) ? S_WAIT_SBF : S_POST;
      S_POST:     if (accept && (remaining == PW'(1))) state_d = S_WAIT_SBF;
      S_WAIT_SBF: if (SBF) state_d = S_SEND;
      S_SEND:     if (handshake && (send_cnt == PW'(DEPTH - 1))) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register, pointers and counters; IDLE holds everything cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      adc_request <= 1'b0;
      write_ptr   <= '0;
      read_ptr    <= '0;
      fill_cnt    <= '0;
      remaining   <= '0;
      send_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      adc_request <= (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
      if (state_q == S_IDLE) begin
        write_ptr <= '0;
        read_ptr  <= '0;
        fill_cnt  <= '0;
        remaining <= '0;
        send_cnt  <= '0;
      end else begin
        if (accept) write_ptr <= write_ptr + 1'b1;
        if (accept && (state_q == S_FILL)) fill_cnt <= fill_cnt + 1'b1;
        if (fire) remaining <= PW'(POST_N);
        else if (accept && (state_q == S_POST)) remaining <= remaining - 1'b1;
        // After the freeze write_ptr points at the oldest sample in the window.
        if ((state_q == S_WAIT_SBF) && SBF) begin
          read_ptr <= write_ptr;
          send_cnt <= '0;
        end else if (handshake) begin
          read_ptr <= read_ptr + 1'b1;
          send_cnt <= send_cnt + 1'b1;
        end
      end
    end
  end

  // Previous-sample history for the crossing detectors (data path, no reset).
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) prev_sample <= '0;
    else if (accept)       prev_sample <= adc_data;
  end

  assign tx_valid             = (state_q == S_SEND);
  assign tx_data              = (state_q == S_SEND) ? rd_data : '0;
  assign state                = state_q;
  assign read_ptr_out         = read_ptr;
  assign write_ptr_out        = write_ptr;
  assign remaining_values_out = remaining;
  assign TRD                  = (state_q == S_WAIT_SBF);
  assign SD                   = (state_q == S_SEND);
  assign CD                   = (state_q == S_DONE);

endmodule
